// File: rtl/video_cmd_pkg.sv
// Shared definitions for the video command queue: opcodes, FSM states,
// dataA field offsets and the queued command payload.
package video_cmd_pkg;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned OPCODE_W   = 4;
    localparam int unsigned FIELD_LSB  = 4;
    localparam int unsigned WORD_W     = 32;

    localparam logic [OPCODE_W-1:0] OP_WBR = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_WSM = 4'h1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HOLD,
        ISSUE,
        WAIT_DONE
    } state_e;

    typedef struct packed {
        logic [WORD_W-1:0] data_a;
        logic [WORD_W-1:0] data_b;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

    function automatic logic [OPCODE_W-1:0] cmd_opcode(input cmd_t c);
        return c.data_a[OPCODE_LSB +: OPCODE_W];
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO (DEPTH x cmd_t) with registered full/empty/level.
// The head entry is presented combinationally on rd_data_c.
module cmd_fifo
    import video_cmd_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  cmd_t                   wr_data_i,
    output cmd_t                   rd_data_c,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    cmd_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_d;
    logic             do_push_c;
    logic             do_pop_c;

    // Registered full blocks a push even when a pop happens in the same cycle.
    always_comb begin
        do_push_c = push_i && !full_o;
        do_pop_c  = pop_i && !empty_o;
        wr_ptr_d  = wr_ptr_q + PTR_W'(do_push_c);
        rd_ptr_d  = rd_ptr_q + PTR_W'(do_pop_c);
        cnt_d     = level_o + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_o  <= '0;
            full_o   <= 1'b0;
            empty_o  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_o  <= cnt_d;
            full_o   <= (cnt_d == CNT_W'(DEPTH));
            empty_o  <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_c = mem_q[rd_ptr_q];

endmodule

// File: rtl/video_cmd_queue.sv
// FIFO-buffered command dispatcher: queues processor writes and issues them
// in order as WBR/WSM strobes. Optional watchdog: VIDEO_CMD_TIMEOUT_EN.
module video_cmd_queue
    import video_cmd_pkg::*;
#(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned ADDR_W         = 14,
    parameter int unsigned REG_W          = 5,
    parameter int unsigned COLOR_W        = 9,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_en,
    input  logic [WORD_W-1:0]      dataA,
    input  logic [WORD_W-1:0]      dataB,
    input  logic                   printing_screen,
    input  logic                   wr_done,
    input  logic                   err_clear,
    output logic                   accepted,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   reg_wr,
    output logic [REG_W-1:0]       reg_index,
    output logic [WORD_W-1:0]      reg_data,
    output logic                   mem_wr,
    output logic [ADDR_W-1:0]      mem_address,
    output logic [COLOR_W-1:0]     mem_data,
    output logic                   overflow,
`ifdef VIDEO_CMD_TIMEOUT_EN
    output logic                   timeout,
`endif
    output logic                   illegal
);

    state_e              state_q, state_d;
    cmd_t                head_c;
    logic [OPCODE_W-1:0] head_op_c;
    logic                push_c;
    logic                pop_c;
    logic                set_illegal_c;
    logic                wsm_sel_c;
    logic                issue_c;
    logic                wsm_q;
    logic                unused_bits_c;

    assign push_c    = clk_en && !full;
    assign head_op_c = cmd_opcode(head_c);

    cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (push_c),
        .pop_i     (pop_c),
        .wr_data_i ({dataA, dataB}),
        .rd_data_c (head_c),
        .full_o    (full),
        .empty_o   (empty),
        .level_o   (level)
    );

`ifdef VIDEO_CMD_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] tmr_q;
    logic             set_timeout_c;
`endif

    always_comb begin
        state_d       = state_q;
        pop_c         = 1'b0;
        set_illegal_c = 1'b0;
`ifdef VIDEO_CMD_TIMEOUT_EN
        set_timeout_c = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!empty) state_d = LOAD;
            end
            LOAD: begin
                if (head_op_c == OP_WBR) begin
                    state_d = ISSUE;
                end else if (head_op_c == OP_WSM) begin
                    state_d = printing_screen ? HOLD : ISSUE;
                end else begin
                    pop_c         = 1'b1;
                    set_illegal_c = 1'b1;
                    state_d       = IDLE;
                end
            end
            HOLD: begin
                if (!printing_screen) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (wr_done) begin
                    pop_c   = 1'b1;
                    state_d = IDLE;
                end
`ifdef VIDEO_CMD_TIMEOUT_EN
                else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    pop_c         = 1'b1;
                    set_timeout_c = 1'b1;
                    state_d       = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // Target type is decoded from the head in LOAD, from the latch afterwards.
        wsm_sel_c = (state_q == LOAD) ? (head_op_c == OP_WSM) : wsm_q;
        issue_c   = (state_d == ISSUE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            accepted    <= 1'b0;
            busy        <= 1'b0;
            reg_wr      <= 1'b0;
            mem_wr      <= 1'b0;
            wsm_q       <= 1'b0;
            reg_index   <= '0;
            reg_data    <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            overflow    <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            state_q  <= state_d;
            accepted <= push_c;
            busy     <= (state_d != IDLE);
            reg_wr   <= issue_c && !wsm_sel_c;
            mem_wr   <= issue_c && wsm_sel_c;
            if (state_q == LOAD) begin
                wsm_q       <= (head_op_c == OP_WSM);
                reg_index   <= head_c.data_a[FIELD_LSB +: REG_W];
                reg_data    <= head_c.data_b;
                mem_address <= head_c.data_a[FIELD_LSB +: ADDR_W];
                mem_data    <= head_c.data_b[COLOR_W-1:0];
            end
            // Sticky flags: a set in the same cycle as err_clear wins.
            if (clk_en && full) overflow <= 1'b1;
            else if (err_clear) overflow <= 1'b0;
            if (set_illegal_c)  illegal <= 1'b1;
            else if (err_clear) illegal <= 1'b0;
        end
    end

`ifdef VIDEO_CMD_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_q   <= '0;
            timeout <= 1'b0;
        end else begin
            tmr_q <= (state_q == WAIT_DONE && state_d == WAIT_DONE) ? tmr_q + 1'b1 : '0;
            if (set_timeout_c)  timeout <= 1'b1;
            else if (err_clear) timeout <= 1'b0;
        end
    end
`endif

    assign unused_bits_c = ^{head_c, 32'(TIMEOUT_CYCLES)};

endmodule

// File: tb/tb_video_cmd_queue.sv
// Directed bench for video_cmd_queue with a transaction-level strobe scoreboard.
module tb_video_cmd_queue;

    logic        clk, reset, clk_en, printing_screen, wr_done, err_clear;
    logic [31:0] dataA, dataB;
    logic        accepted, full, empty, busy, reg_wr, mem_wr, overflow, illegal;
    logic [4:0]  level;
    logic [4:0]  reg_index;
    logic [31:0] reg_data;
    logic [13:0] mem_address;
    logic [8:0]  mem_data;

    video_cmd_queue dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .dataA(dataA), .dataB(dataB),
        .printing_screen(printing_screen), .wr_done(wr_done), .err_clear(err_clear),
        .accepted(accepted), .full(full), .empty(empty), .level(level), .busy(busy),
        .reg_wr(reg_wr), .reg_index(reg_index), .reg_data(reg_data),
        .mem_wr(mem_wr), .mem_address(mem_address), .mem_data(mem_data),
        .overflow(overflow), .illegal(illegal)
    );

    typedef struct {
        bit          is_wsm;
        logic [31:0] sel;
        logic [31:0] data;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;
    bit   auto_done = 1;
    int   kick_req = 0;
    int   kick_ack = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected strobe derived from the command encoding; illegal opcodes produce none.
    function automatic void model_push(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (a[3:0] == 4'h0) begin
            e.is_wsm = 1'b0; e.sel = (a >> 4) & 32'h1F; e.data = b;
            expq.push_back(e);
        end else if (a[3:0] == 4'h1) begin
            e.is_wsm = 1'b1; e.sel = (a >> 4) & 32'h3FFF; e.data = b & 32'h1FF;
            expq.push_back(e);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit exp_acc);
        clk_en = 1'b1; dataA = a; dataB = b;
        if (exp_acc) model_push(a, b);
        tick();
        clk_en = 1'b0;
        chk("accepted", 32'(accepted), 32'(exp_acc));
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (expq.size() == 0 && !busy && empty) break;
        end
        chk("drain_busy", 32'(busy), 32'd0);
        chk("drain_pending", 32'(expq.size()), 32'd0);
    endtask

    // Scoreboard: every strobe must match the next expected command, in order.
    always @(negedge clk) begin
        if (!reset && (reg_wr || mem_wr)) begin
            chk("strobe_exclusive", 32'(reg_wr & mem_wr), 32'd0);
            if (mem_wr) chk("wsm_while_printing", 32'(printing_screen), 32'd0);
            if (expq.size() == 0) begin
                chk("unexpected_strobe", 32'(reg_wr | mem_wr), 32'd0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("strobe_kind", 32'(mem_wr), 32'(e.is_wsm));
                if (e.is_wsm) begin
                    chk("mem_address", 32'(mem_address), e.sel);
                    chk("mem_data", 32'(mem_data), e.data);
                end else begin
                    chk("reg_index", 32'(reg_index), e.sel);
                    chk("reg_data", reg_data, e.data);
                end
            end
        end
    end

    // Target responder: one-cycle wr_done in the cycle after a strobe, or on request.
    initial begin
        wr_done = 1'b0;
        forever begin
            @(negedge clk);
            if (((reg_wr || mem_wr) && auto_done) || (kick_req != kick_ack)) begin
                kick_ack = kick_req;
                @(posedge clk); #1 wr_done = 1'b1;
                @(posedge clk); #1 wr_done = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clk_en = 1'b0; dataA = '0; dataB = '0;
        printing_screen = 1'b0; err_clear = 1'b0;
        tick(); tick(); tick();

        // Reset state
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", 32'({accepted, reg_wr, mem_wr, overflow, illegal}), 32'd0);
        reset = 1'b0;
        tick();

        // WBR: strobe two cycles after accept, popped after wr_done
        send(32'h00000050, 32'h29624000, 1'b1);
        tick();
        chk("wbr_no_early_strobe", 32'(reg_wr), 32'd0);
        tick();
        chk("wbr_reg_wr", 32'(reg_wr), 32'd1);
        chk("wbr_index_lit", 32'(reg_index), 32'd5);
        chk("wbr_data_lit", reg_data, 32'h29624000);
        tick();
        chk("wbr_pulse_end", 32'(reg_wr), 32'd0);
        tick();
        chk("wbr_empty", 32'(empty), 32'd1);
        chk("wbr_idle", 32'(busy), 32'd0);

        // WSM held off while printing
        printing_screen = 1'b1;
        send(32'h0003FFF1, 32'd12, 1'b1);
        tick();
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("hold_busy", 32'(busy), 32'd1);
            chk("hold_mem_wr", 32'(mem_wr), 32'd0);
        end
        printing_screen = 1'b0;
        tick();
        chk("wsm_mem_wr", 32'(mem_wr), 32'd1);
        chk("wsm_addr_lit", 32'(mem_address), 32'h3FFF);
        chk("wsm_data_lit", 32'(mem_data), 32'd12);
        wait_idle(20);

        // Fill: 16 accepted, 17th dropped with overflow
        auto_done = 1'b0;
        for (int i = 0; i < 17; i++) begin
            clk_en = 1'b1; dataA = 32'(i) << 4; dataB = 32'h1000 + 32'(i);
            if (i < 16) model_push(dataA, dataB);
            tick();
            chk("fill_accepted", 32'(accepted), (i < 16) ? 32'd1 : 32'd0);
        end
        clk_en = 1'b0;
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_level", 32'(level), 32'd16);
        chk("fill_overflow", 32'(overflow), 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("overflow_clear", 32'(overflow), 32'd0);
        chk("still_full", 32'(full), 32'd1);
        auto_done = 1'b1;
        kick_req++;
        wait_idle(200);
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_full", 32'(full), 32'd0);

        // Illegal opcode dropped, following WBR still issues
        send(32'h00000007, 32'hDEADBEEF, 1'b1);
        send(32'h00000030, 32'h0000CAFE, 1'b1);
        wait_idle(30);
        chk("illegal_set", 32'(illegal), 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("illegal_clear", 32'(illegal), 32'd0);

        // Reset in HOLD with three entries queued
        printing_screen = 1'b1;
        send(32'h00000011, 32'h1A5, 1'b1);
        send(32'h00000021, 32'h0F0, 1'b1);
        send(32'h00000031, 32'h00F, 1'b1);
        tick(); tick(); tick();
        chk("hold_pre_busy", 32'(busy), 32'd1);
        chk("hold_pre_level", 32'(level), 32'd3);
        chk("hold_pre_addr", 32'(mem_address), 32'd1);
        reset = 1'b1;
        expq.delete();
        #1;
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_addr", 32'(mem_address), 32'd0);
        chk("mid_rst_mdata", 32'(mem_data), 32'd0);
        chk("mid_rst_rdata", reg_data, 32'd0);
        chk("mid_rst_flags", 32'({accepted, full, reg_wr, mem_wr, overflow, illegal}), 32'd0);
        tick(); tick();
        reset = 1'b0;
        printing_screen = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("post_rst_empty", 32'(empty), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
